// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array feeder.
// Operand slices, feeder states and the skew-valid rule.
package sa_pkg;

  localparam int D  = 4;
  localparam int IW = $clog2(D);
  localparam int TW = $clog2(2 * D - 1);

  typedef logic [15:0] fp16_t;

  typedef struct packed {
    fp16_t [D-1:0] a;
    fp16_t [D-1:0] b;
  } slice_t;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    GAP
  } feed_state_e;

  function automatic logic lane_valid(
    input logic [TW-1:0] t,
    input int            i
  );
    int k;
    k = int'(t) - i;
    return (k >= 0) && (k < D);
  endfunction

endpackage

// File: rtl/sa_feeder_if.sv
// Unskewed operand beat stream into the feeder.
// One beat carries one slice: lane i of A and of B.
interface sa_feeder_if;
  import sa_pkg::*;

  logic          S_VALID;
  logic          S_READY;
  fp16_t [D-1:0] S_A;
  fp16_t [D-1:0] S_B;

  modport master (
    output S_VALID, S_A, S_B,
    input  S_READY
  );

  modport slave (
    input  S_VALID, S_A, S_B,
    output S_READY
  );

endinterface

// File: rtl/sa_feed_bank.sv
// One ping-pong bank: D slices plus a full flag.
// Read is per lane so each lane can pick its own skewed slice.
module sa_feed_bank
  import sa_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [IW-1:0]        widx_i,
  input  slice_t               wslice_i,
  input  logic                 set_i,
  input  logic                 clr_i,
  output logic                 full_o,
  input  logic [D-1:0][IW-1:0] ridx_i,
  output fp16_t [D-1:0]        ra_o,
  output fp16_t [D-1:0]        rb_o
);

  slice_t mem_q [D];
  logic   full_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[widx_i] <= wslice_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     full_q <= 1'b0;
    else if (set_i) full_q <= 1'b1;
    else if (clr_i) full_q <= 1'b0;
  end

  always_comb begin
    ra_o = '0;
    rb_o = '0;
    for (int i = 0; i < D; i++) begin
      ra_o[i] = mem_q[ridx_i[i]].a[i];
      rb_o[i] = mem_q[ridx_i[i]].b[i];
    end
  end

  assign full_o = full_q;

endmodule

// File: rtl/sa_feeder.sv
// Loads operand pairs into a ping-pong buffer and replays them
// to the systolic array as a diagonal-skewed wavefront.
module sa_feeder
  import sa_pkg::*;
#(
  parameter int MIN_GAP = 8
) (
  input  logic                   CLK,
  input  logic                   RSTn,
  sa_feeder_if.slave             s_if,
  output logic [D-1:0]           M_DVI,
  output fp16_t [1:0][D-1:0]     M_DI,
  output logic                   FEED_DONE,
  output logic                   BUSY
);

  localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  feed_state_e st_q, st_d;
  logic [TW-1:0] t_q, t_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] beat_q, beat_d;
  logic wptr_q, wptr_d, rptr_q, rptr_d;
  logic ready_q, ready_d;
  logic [D-1:0] dvi_q, dvi_d;
  fp16_t [1:0][D-1:0] di_q, di_d;
  logic done_q, busy_q, busy_d;

  logic [1:0] full, set, clr, full_set, full_nx;
  logic accept, last_beat, done;
  logic [D-1:0][IW-1:0] ridx;
  fp16_t [D-1:0] ra0, rb0, ra1, rb1, ra, rb;
  slice_t wslice;

  assign accept    = s_if.S_VALID & ready_q;
  assign last_beat = accept && (beat_q == IW'(D - 1));
  assign done      = (st_q == FEED) && (t_q == TW'(2 * D - 2));
  assign wslice    = '{a: s_if.S_A, b: s_if.S_B};

  assign set[0] = last_beat && !wptr_q;
  assign set[1] = last_beat && wptr_q;
  assign clr[0] = done && !rptr_q;
  assign clr[1] = done && rptr_q;

  sa_feed_bank u_bank0 (
    .clk(CLK), .rst_n(RSTn),
    .we_i(accept && !wptr_q), .widx_i(beat_q),
    .wslice_i(wslice), .set_i(set[0]), .clr_i(clr[0]),
    .full_o(full[0]), .ridx_i(ridx), .ra_o(ra0), .rb_o(rb0)
  );

  sa_feed_bank u_bank1 (
    .clk(CLK), .rst_n(RSTn),
    .we_i(accept && wptr_q), .widx_i(beat_q),
    .wslice_i(wslice), .set_i(set[1]), .clr_i(clr[1]),
    .full_o(full[1]), .ridx_i(ridx), .ra_o(ra1), .rb_o(rb1)
  );

  assign ra = rptr_q ? ra1 : ra0;
  assign rb = rptr_q ? rb1 : rb0;

  always_comb begin
    beat_d = beat_q;
    wptr_d = wptr_q;
    if (accept) begin
      if (last_beat) begin
        beat_d = '0;
        wptr_d = ~wptr_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // A freed bank only re-opens the loader one cycle later.
  assign full_set = full | set;
  assign full_nx  = full_set & ~clr;
  assign ready_d  = ~full_set[wptr_d];

  always_comb begin
    st_d   = st_q;
    t_d    = t_q;
    gap_d  = gap_q;
    rptr_d = rptr_q;
    unique case (st_q)
      IDLE: begin
        if (full[rptr_q]) begin
          st_d = FEED;
          t_d  = '0;
        end
      end
      FEED: begin
        if (done) begin
          rptr_d = ~rptr_q;
          t_d    = '0;
          gap_d  = '0;
          if (MIN_GAP == 0)
            st_d = full[~rptr_q] ? FEED : IDLE;
          else
            st_d = GAP;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(MIN_GAP - 1))
          st_d = full[rptr_q] ? FEED : IDLE;
        else
          gap_d = gap_q + 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_comb begin
    ridx  = '0;
    dvi_d = '0;
    di_d  = '0;
    for (int i = 0; i < D; i++) begin
      ridx[i] = IW'(t_q - TW'(i));
      if (st_q == FEED && lane_valid(t_q, i)) begin
        dvi_d[i]    = 1'b1;
        di_d[0][i]  = ra[i];
        di_d[1][i]  = rb[i];
      end
    end
  end

  assign busy_d = (|full_nx) | (st_d != IDLE) | (beat_d != '0);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_q    <= IDLE;
      t_q     <= '0;
      gap_q   <= '0;
      beat_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      ready_q <= 1'b0;
      dvi_q   <= '0;
      di_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      t_q     <= t_d;
      gap_q   <= gap_d;
      beat_q  <= beat_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ready_q <= ready_d;
      dvi_q   <= dvi_d;
      di_q    <= di_d;
      done_q  <= done;
      busy_q  <= busy_d;
    end
  end

  assign s_if.S_READY = ready_q;
  assign M_DVI        = dvi_q;
  assign M_DI         = di_q;
  assign FEED_DONE    = done_q;
  assign BUSY         = busy_q;

endmodule
